// File: rtl/bus_slave_responder.sv
// ---------------------------------------------------------------------------
// bus_slave_responder
//   Slave-side responder for the shared two-master/two-slave bus. One
//   instance sits behind each slave select line. It holds a small register
//   memory and generates the ready/response/split handshake that the bus
//   controller samples to grant masters and to end transfers.
//
//   Transfer types:
//     - in-range read/write : WAIT_CYCLES wait states, then a one-cycle
//                             OKAY data phase
//     - out-of-range address: two-cycle ERROR response, no memory write
//     - in-range read with split_en: SPLIT, then HOLD with split=1 for
//       SPLIT_CYCLES cycles (RETRY to anyone selecting us meanwhile), then
//       RESUME. The next select in RESUME is answered from the buffered word
//       with no wait states.
//
// Ports
//   clk        : bus clock, rising edge
//   rst        : asynchronous reset, active low
//   sel        : slave select from the bus controller
//   read_write : 1 = write, 0 = read
//   addr       : transfer address (ADDR_W)
//   wdata      : write data (DATA_W)
//   split_en   : 1 = in-range reads take the SPLIT path
//   ready      : transfer complete / slave free (registered)
//   response   : 00 OKAY, 01 ERROR, 10 RETRY, 11 SPLIT (registered)
//   split      : high while a split read is pending (registered)
//   rdata      : read data, valid when ready=1 and response=00 in DATA
// ---------------------------------------------------------------------------
module bus_slave_responder #(
  parameter int DATA_W       = 8,
  parameter int ADDR_W       = 8,
  parameter int MEM_DEPTH    = 16,
  parameter int WAIT_CYCLES  = 2,
  parameter int SPLIT_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel,
  input  logic              read_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              split_en,
  output logic              ready,
  output logic [1:0]        response,
  output logic              split,
  output logic [DATA_W-1:0] rdata
);

  // One shared down-counter serves WAIT, ERR and HOLD; it is reloaded on
  // every state entry and never wraps.
  localparam int CNT_MAX = (WAIT_CYCLES > SPLIT_CYCLES) ? WAIT_CYCLES : SPLIT_CYCLES;
  localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
  localparam int IDX_W   = (MEM_DEPTH < 2) ? 1 : $clog2(MEM_DEPTH);

  localparam logic [CNT_W-1:0] WAIT_LD  = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] SPLIT_LD = CNT_W'(SPLIT_CYCLES - 1);

  localparam logic [1:0] RSP_OKAY  = 2'b00;
  localparam logic [1:0] RSP_ERROR = 2'b01;
  localparam logic [1:0] RSP_RETRY = 2'b10;
  localparam logic [1:0] RSP_SPLIT = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_DATA   = 3'd2,
    S_ERR    = 3'd3,
    S_SPLIT  = 3'd4,
    S_HOLD   = 3'd5,
    S_RESUME = 3'd6
  } state_e;

  // Request captured when leaving IDLE so WAIT ignores the live bus.
  typedef struct packed {
    logic              we;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] wdata;
  } req_t;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ready_q, ready_d;
  logic [1:0]        resp_q, resp_d;
  logic              split_q, split_d;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] buf_q;
  req_t              req_q;
  req_t              cur_req;
  logic [DATA_W-1:0] mem_q [MEM_DEPTH];

  logic [31:0]       addr_ext;
  logic              in_range;

  assign addr_ext = 32'(addr);
  assign in_range = (addr_ext < MEM_DEPTH);

  // In IDLE the request is taken straight from the bus (needed when
  // WAIT_CYCLES=0 and DATA follows IDLE directly); later from the latch.
  always_comb begin
    cur_req = req_q;
    if (state_q == S_IDLE) begin
      cur_req.we    = read_write;
      cur_req.idx   = addr[IDX_W-1:0];
      cur_req.wdata = wdata;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and registered-output logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (sel) begin
          // Address check wins over split_en; writes never split.
          if (!in_range) begin
            state_d = S_ERR;
            cnt_d   = CNT_W'(1);
          end else if (!read_write && split_en) begin
            state_d = S_SPLIT;
          end else if (WAIT_CYCLES == 0) begin
            state_d = S_DATA;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WAIT_LD;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_DATA;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_DATA: state_d = S_IDLE;
      S_ERR: begin
        // cnt=1 marks the first ERROR cycle, cnt=0 the second.
        if (cnt_q != '0) cnt_d   = '0;
        else             state_d = S_IDLE;
      end
      S_SPLIT: begin
        if (SPLIT_CYCLES == 0) begin
          state_d = S_RESUME;
        end else begin
          state_d = S_HOLD;
          cnt_d   = SPLIT_LD;
        end
      end
      S_HOLD: begin
        // sel does not restart the hold window.
        if (cnt_q == '0) state_d = S_RESUME;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_RESUME: begin
        if (sel) state_d = S_DATA;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Outputs are decoded from the state being entered so they appear in
    // the same cycle as the state itself.
    ready_d = 1'b1;
    resp_d  = RSP_OKAY;
    split_d = 1'b0;
    case (state_d)
      S_WAIT: ready_d = 1'b0;
      S_ERR: begin
        ready_d = (state_q == S_ERR);
        resp_d  = RSP_ERROR;
      end
      S_SPLIT: begin
        ready_d = 1'b0;
        resp_d  = RSP_SPLIT;
      end
      S_HOLD: begin
        ready_d = 1'b0;
        split_d = 1'b1;
        // A master selecting us while the split is held is told to retry.
        resp_d  = (state_q == S_HOLD && sel) ? RSP_RETRY : RSP_OKAY;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      resp_q  <= RSP_OKAY;
      split_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      resp_q  <= resp_d;
      split_q <= split_d;
    end
  end

  // -------------------------------------------------------------------------
  // Request latch, split buffer, read data
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_q   <= '0;
      buf_q   <= '0;
      rdata_q <= '0;
    end else begin
      if (state_q == S_IDLE && state_d != S_IDLE) req_q <= cur_req;
      if (state_q == S_IDLE && state_d == S_SPLIT) buf_q <= mem_q[cur_req.idx];
      if (state_d == S_DATA) begin
        // The resume path answers from the buffer and never touches memory.
        if (state_q == S_RESUME) rdata_q <= buf_q;
        else if (!cur_req.we)    rdata_q <= mem_q[cur_req.idx];
      end
    end
  end

  // Memory write commits on the edge entering DATA; ERR and the resume
  // path never write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
    end else if (state_d == S_DATA && state_q != S_RESUME && cur_req.we) begin
      mem_q[cur_req.idx] <= cur_req.wdata;
    end
  end

  assign ready    = ready_q;
  assign response = resp_q;
  assign split    = split_q;
  assign rdata    = rdata_q;

endmodule

// File: tb/tb_bus_slave_responder.sv
// ---------------------------------------------------------------------------
// tb_bus_slave_responder
//   Scoreboard bench. Each transfer task pushes the per-cycle expected
//   {ready,response,split,rdata} of the main instance (WAIT_CYCLES=2) when it
//   drives the bus; a negedge monitor pops and compares. A second instance
//   built with WAIT_CYCLES=0 shares the inputs and is checked directly for
//   its single-edge latency.
// ---------------------------------------------------------------------------
module tb_bus_slave_responder;

  localparam int WC = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sel = 1'b0;
  logic       rw  = 1'b0;
  logic       sen = 1'b0;
  logic [7:0] addr  = '0;
  logic [7:0] wdata = '0;

  logic       ready,   split;
  logic [1:0] resp;
  logic [7:0] rdata;
  logic       ready_z, split_z;
  logic [1:0] resp_z;
  logic [7:0] rdata_z;

  always #5 clk = ~clk;

  bus_slave_responder #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(16),
                        .WAIT_CYCLES(WC), .SPLIT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .sel(sel), .read_write(rw), .addr(addr),
    .wdata(wdata), .split_en(sen), .ready(ready), .response(resp),
    .split(split), .rdata(rdata)
  );

  bus_slave_responder #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(16),
                        .WAIT_CYCLES(0), .SPLIT_CYCLES(4)) dut_zw (
    .clk(clk), .rst(rst), .sel(sel), .read_write(rw), .addr(addr),
    .wdata(wdata), .split_en(sen), .ready(ready_z), .response(resp_z),
    .split(split_z), .rdata(rdata_z)
  );

  typedef struct {
    logic [11:0] v;
    string       tag;
  } exp_t;

  exp_t       q[$];
  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] mem_m [16];
  logic [7:0] rd_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic push(input string tag, input logic r, input logic [1:0] s,
                      input logic p, input logic [7:0] d);
    exp_t e;
    e.v   = {r, s, p, d};
    e.tag = tag;
    q.push_back(e);
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (rst && q.size() != 0) begin
      e = q.pop_front();
      chk(e.tag, 32'({ready, resp, split, rdata}), 32'(e.v));
    end
  end

  // Wait for the monitor to consume all expectations; leaves us 1ns past a
  // posedge, ready to drive the next transfer.
  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    if (q.size() != 0) begin
      chk("drain_timeout", 32'(q.size()), 32'd0);
      q.delete();
    end
    #1;
  endtask

  // Plain (non-split) transfer. zw=1 also checks the zero-wait instance one
  // edge after the sampling edge.
  task automatic xfer(input string tg, input logic w, input logic [7:0] a,
                      input logic [7:0] d, input logic se,
                      input logic zw, input logic [7:0] zrd);
    sel = 1'b1; rw = w; addr = a; wdata = d; sen = se;
    push(tg, 1'b1, 2'b00, 1'b0, rd_m);            // still IDLE
    if (a >= 8'd16) begin
      push(tg, 1'b0, 2'b01, 1'b0, rd_m);
      push(tg, 1'b1, 2'b01, 1'b0, rd_m);
      push(tg, 1'b1, 2'b00, 1'b0, rd_m);
    end else begin
      repeat (WC) push(tg, 1'b0, 2'b00, 1'b0, rd_m);
      if (w) mem_m[a[3:0]] = d;
      else   rd_m = mem_m[a[3:0]];
      push(tg, 1'b1, 2'b00, 1'b0, rd_m);          // DATA
      push(tg, 1'b1, 2'b00, 1'b0, rd_m);          // back in IDLE
    end
    @(posedge clk); #1;
    sel = 1'b0;
    if (zw) begin
      @(negedge clk);
      chk({tg, "_zw"}, 32'({ready_z, resp_z, split_z, rdata_z}),
          32'({1'b1, 2'b00, 1'b0, zrd}));
    end
    drain();
  endtask

  // Split read with one sel pulse during HOLD, then a resume select that
  // carries a write to addr 9 which must not reach memory.
  task automatic split_rd(input string tg, input logic [7:0] a);
    sel = 1'b1; rw = 1'b0; addr = a; sen = 1'b1;
    push(tg, 1'b1, 2'b00, 1'b0, rd_m);            // IDLE
    push(tg, 1'b0, 2'b11, 1'b0, rd_m);            // SPLIT
    push(tg, 1'b0, 2'b00, 1'b1, rd_m);            // HOLD 1
    push(tg, 1'b0, 2'b10, 1'b1, rd_m);            // HOLD 2, RETRY
    push(tg, 1'b0, 2'b00, 1'b1, rd_m);            // HOLD 3
    push(tg, 1'b0, 2'b00, 1'b1, rd_m);            // HOLD 4
    push(tg, 1'b1, 2'b00, 1'b0, rd_m);            // RESUME
    rd_m = mem_m[a[3:0]];
    push(tg, 1'b1, 2'b00, 1'b0, rd_m);            // DATA from buffer
    push(tg, 1'b1, 2'b00, 1'b0, rd_m);            // IDLE
    @(posedge clk); #1; sel = 1'b0; sen = 1'b0;   // now in SPLIT
    @(posedge clk); #1; sel = 1'b1;               // now in HOLD
    @(posedge clk); #1; sel = 1'b0;
    repeat (3) @(posedge clk);
    #1; sel = 1'b1; rw = 1'b1; addr = 8'd9; wdata = 8'hEE;  // now in RESUME
    @(posedge clk); #1; sel = 1'b0; rw = 1'b0;
    drain();
  endtask

  initial begin : wdog
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 16; i++) mem_m[i] = '0;
    rd_m = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset",    32'({ready, resp, split, rdata}),         32'({1'b1, 2'b00, 1'b0, 8'h00}));
    chk("reset_zw", 32'({ready_z, resp_z, split_z, rdata_z}), 32'({1'b1, 2'b00, 1'b0, 8'h00}));
    rst = 1'b1;
    @(posedge clk); #1;

    // Zero-wait latency on the shared bus, then the main instance traffic.
    xfer("rd0_init", 1'b0, 8'd0,  8'h00, 1'b0, 1'b1, 8'h00);
    xfer("wr0",      1'b1, 8'd0,  8'h5A, 1'b0, 1'b1, 8'h00);
    xfer("rd0",      1'b0, 8'd0,  8'h00, 1'b0, 1'b1, 8'h5A);
    xfer("wr3",      1'b1, 8'd3,  8'hA5, 1'b0, 1'b0, 8'h00);
    xfer("rd3",      1'b0, 8'd3,  8'h00, 1'b0, 1'b0, 8'h00);
    xfer("wr16_err", 1'b1, 8'd16, 8'hFF, 1'b0, 1'b0, 8'h00);
    xfer("rd16_err", 1'b0, 8'd16, 8'h00, 1'b0, 1'b0, 8'h00);
    xfer("rd255_err",1'b0, 8'd255,8'h00, 1'b1, 1'b0, 8'h00);  // error beats split_en
    xfer("wr15",     1'b1, 8'd15, 8'h77, 1'b0, 1'b0, 8'h00);
    xfer("rd15",     1'b0, 8'd15, 8'h00, 1'b0, 1'b0, 8'h00);
    xfer("wr7_sen",  1'b1, 8'd7,  8'h3E, 1'b1, 1'b0, 8'h00);  // writes never split
    xfer("rd7",      1'b0, 8'd7,  8'h00, 1'b0, 1'b0, 8'h00);
    split_rd("split3", 8'd3);
    xfer("rd9",      1'b0, 8'd9,  8'h00, 1'b0, 1'b0, 8'h00);
    xfer("rd3_again",1'b0, 8'd3,  8'h00, 1'b0, 1'b0, 8'h00);

    // Async reset in the middle of the WAIT phase of a write to addr 5.
    sel = 1'b1; rw = 1'b1; addr = 8'd5; wdata = 8'h3C; sen = 1'b0;
    @(posedge clk); #1;
    sel = 1'b0;
    chk("pre_rst_wait", 32'(ready), 32'd0);
    #2 rst = 1'b0;
    #1;
    chk("rst_async", 32'({ready, resp, split, rdata}), 32'({1'b1, 2'b00, 1'b0, 8'h00}));
    @(negedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 16; i++) mem_m[i] = '0;
    rd_m = '0;
    @(posedge clk); #1;
    xfer("wr_dummy", 1'b1, 8'd1,  8'h11, 1'b0, 1'b0, 8'h00);
    xfer("rd5_rst",  1'b0, 8'd5,  8'h00, 1'b0, 1'b0, 8'h00);
    xfer("rd1",      1'b0, 8'd1,  8'h00, 1'b0, 1'b0, 8'h00);
    xfer("rd3_rst",  1'b0, 8'd3,  8'h00, 1'b0, 1'b0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
